lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit of the pipelined RISC-V core.
- Takes the M-stage memory operation (address, write data, write enable, mem_dt_e width) and drives a variable-latency data-memory bus with a valid/ready request and a response strobe.
- Performs sub-word lane alignment and store byte strobes, and sign/zero-extends load results for writeback.
- Raises stall to the hazard unit while an access is outstanding, and reports misalignment and timeout through errno_e.

Parameters:
- TIMEOUT, 255, max cycles in WAIT before abort; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m_en  in  1  memory op valid in M stage
- m_we  in  1  1=store, 0=load
- m_addr  in  32  byte address
- m_wd  in  32  store data, LSB-justified
- m_dt  in  mem_dt_e  BYTE/HALF/WORD/UBYTE/UHALF
- m_rd  out  32  extended load data, valid when done=1
- done  out  1  op completes this cycle
- stall  out  1  freeze IF..M stages
- err  out  errno_e  ENOERR/EALIGN/ETIMEOUT, valid with done
- req_valid  out  1  bus request
- req_ready  in  1  bus accepts request
- req_we  out  1  write request
- req_addr  out  32  word address, {m_addr[31:2],2'b00}
- req_wstrb  out  4  byte enables
- req_wdata  out  32  lane-shifted store data
- resp_valid  in  1  response/ack strobe, one cycle
- resp_rdata  in  32  read word

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0. req_valid=0, done=0, stall=0, m_rd=0, err=ENOERR.
- FSM states: IDLE, REQ, WAIT.
- IDLE, m_en=0: all outputs idle.
- IDLE, m_en=1, misaligned (HALF/UHALF with addr[0]=1; WORD with addr[1:0]!=0):
  - same cycle: done=1, err=EALIGN, m_rd=0, stall=0, req_valid=0.
  - remain IDLE.
- IDLE, m_en=1, aligned:
  - req_valid=1 combinationally; stall=1.
  - req_ready=1: go WAIT. Else go REQ.
- REQ: req_valid=1, stall=1. Address, strobes and data are recomputed from the m_* inputs, which the pipeline holds stable while stall=1. On req_ready go WAIT.
- WAIT:
  - req_valid=0; counter increments each cycle.
  - resp_valid=1: done=1, stall=0, err=ENOERR, m_rd=extended data (combinational from resp_rdata), go IDLE, counter=0.
  - Counter reaches TIMEOUT without resp_valid: done=1, stall=0, err=ETIMEOUT, m_rd=0, go IDLE.
- Minimum latency with a zero-wait bus (req_ready=1 in cycle N, resp_valid in N+1):
  - stall high for 1 cycle (N); done in N+1.
  - The hazard unit adds this stall on top of the existing lw use stall.
- resp_valid in IDLE or REQ: ignored.
- req_ready while req_valid=0: ignored.
- Store strobes by m_dt and addr[1:0]:
  - BYTE: wstrb = 1<<a; wdata = {4{wd[7:0]}}.
  - HALF: wstrb = 0011 (a=0) or 1100 (a=2); wdata = {2{wd[15:0]}}.
  - WORD: wstrb = 1111; wdata = wd.
  - UBYTE/UHALF stores behave as BYTE/HALF.
- Load extraction: lane selected by addr[1:0].
  - BYTE/HALF sign-extend; UBYTE/UHALF zero-extend; WORD passes through.
  - Loads drive req_wstrb=0000.
- Timeout compare: counter >= TIMEOUT, 8-bit, no wrap. TIMEOUT=0 aborts on the first WAIT cycle.
- Reset asserted mid-REQ/WAIT: outstanding access abandoned; any later response is ignored.

Decomposition:
- Shared packages:
  - mem package: mem_dt_e (existing).
  - errno package: errno_e, gains EALIGN and ETIMEOUT.
  - lsu.svh: lsu_state_e {IDLE, REQ, WAIT}.
- Sub-module lsu_align, combinational:
  - Inputs: m_dt, addr[1:0], m_wd, resp_rdata.
  - Outputs: wstrb, wdata, extended rdata, misaligned flag.
  - Unit-tested in isolation.

Test Plan:
- lw at addr 0x0, memory word 0xdeadc0de, zero-wait bus:
  - req_addr=0x0, req_wstrb=0000, stall=1 for 1 cycle.
  - Next cycle: done=1, m_rd=0xdeadc0de, err=ENOERR.
- lb / lbu at addr 0x3, word 0xdeadc0de: m_rd=0xffffffde (lb) and 0x000000de (lbu).
- lh / lhu at addr 0x2, word 0x8001c0de: m_rd=0xffff8001 (lh) and 0x00008001 (lhu).
- sh at addr 0x6, m_wd=0x1234abcd: req_addr=0x4, req_we=1, req_wstrb=1100, req_wdata=0xabcdabcd.
- sb at addr 0x1, m_wd=0x55: req_wstrb=0010, req_wdata=0x55555555.
- Misaligned access:
  - lw at addr 0x2: same cycle done=1, err=EALIGN, req_valid never asserted, stall=0.
  - lh at addr 0x1: same result, err=EALIGN.
- Back-pressure:
  - req_ready low for 3 cycles, resp_valid 2 cycles after acceptance: stall high exactly 5 cycles, m_rd correct on done.
  - TIMEOUT=4 with no response: ETIMEOUT after 4 WAIT cycles.
- Reset mid-op:
  - rst low during WAIT: outputs return to reset values immediately.
  - Late resp_valid ignored; next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared memory-access width, error code and LSU state types
package lsu_mem_stage_pkg;

    typedef enum logic [2:0] {BYTE, HALF, WORD, UBYTE, UHALF} mem_dt_e;

    typedef enum logic [1:0] {ENOERR, EALIGN, ETIMEOUT} errno_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_mem_stage_align: store lane/strobe generation, load lane extraction and extension, misalignment detect
//   m_dt, addr[1:0]  access width and byte offset
//   m_wd             LSB-justified store data
//   resp_rdata       raw read word from the bus
//   wstrb, wdata     byte enables and replicated store data
//   rdata            sign/zero-extended load result
//   misaligned       access crosses its natural boundary
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
(
    input  mem_dt_e     m_dt,
    input  logic [1:0]  addr,
    input  logic [31:0] m_wd,
    input  logic [31:0] resp_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic        is_b;
    logic        is_h;
    logic [15:0] lane;

    assign is_b = m_dt == BYTE || m_dt == UBYTE;
    assign is_h = m_dt == HALF || m_dt == UHALF;

    always_comb begin
        lane       = 16'(resp_rdata >> {addr, 3'b000});
        wstrb      = is_b ? 4'b0001 << addr : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata      = is_b ? {4{m_wd[7:0]}} : is_h ? {2{m_wd[15:0]}} : m_wd;
        misaligned = is_h ? addr[0] : !is_b && addr != 2'b00;
        rdata      = m_dt == BYTE  ? {{24{lane[7]}}, lane[7:0]} :
                     m_dt == HALF  ? {{16{lane[15]}}, lane} :
                     m_dt == UBYTE ? {24'b0, lane[7:0]} :
                     m_dt == UHALF ? {16'b0, lane} : resp_rdata;
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: M-stage load/store unit driving a valid/ready data bus with response strobe
//   clk, rst (async, active-low)
//   m_en/m_we/m_addr/m_wd/m_dt   memory op from the M stage, held stable while stall=1
//   m_rd, done, err              load result and completion status
//   stall                        freeze IF..M while an access is outstanding
//   req_*                        bus request channel
//   resp_valid, resp_rdata       bus response
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_en,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wd,
    input  mem_dt_e     m_dt,
    output logic [31:0] m_rd,
    output logic        done,
    output logic        stall,
    output errno_e      err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    lsu_state_e       state;
    lsu_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       wstrb;
    logic [31:0]      ext;
    logic             mis;
    logic             tmo;

    lsu_mem_stage_align u_align (
        .m_dt       (m_dt),
        .addr       (m_addr[1:0]),
        .m_wd       (m_wd),
        .resp_rdata (resp_rdata),
        .wstrb      (wstrb),
        .wdata      (req_wdata),
        .rdata      (ext),
        .misaligned (mis)
    );

    assign tmo       = cnt >= CNT_W'(TIMEOUT);
    assign req_addr  = {m_addr[31:2], 2'b00};
    assign req_we    = m_we;
    assign req_wstrb = m_we ? wstrb : 4'b0000;

    // Outputs are gated by rst so an asynchronous reset idles the bus immediately,
    // even while the pipeline still presents m_en.
    always_comb begin
        state_nx  = state;
        req_valid = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        err       = ENOERR;
        m_rd      = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (m_en && mis) begin
                        done = 1'b1;
                        err  = EALIGN;
                    end else if (m_en) begin
                        req_valid = 1'b1;
                        stall     = 1'b1;
                        state_nx  = req_ready ? WAIT : REQ;
                    end
                end
                REQ: begin
                    req_valid = 1'b1;
                    stall     = 1'b1;
                    state_nx  = req_ready ? WAIT : REQ;
                end
                WAIT: begin
                    if (resp_valid) begin
                        done     = 1'b1;
                        m_rd     = ext;
                        state_nx = IDLE;
                    end else if (tmo) begin
                        done     = 1'b1;
                        err      = ETIMEOUT;
                        state_nx = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // cnt counts completed WAIT cycles; the abort fires once it reaches TIMEOUT,
    // so with TIMEOUT <= 255 it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT && state_nx == WAIT) ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized check of lsu_mem_stage against a transaction-level model
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_en = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    mem_dt_e     m_dt = WORD;
    logic [31:0] m_rd;
    logic        done;
    logic        stall;
    errno_e      err;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wd       (m_wd),
        .m_dt       (m_dt),
        .m_rd       (m_rd),
        .done       (done),
        .stall      (stall),
        .err        (err),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input mem_dt_e dt);
        return dt == WORD ? 4 : (dt == HALF || dt == UHALF) ? 2 : 1;
    endfunction

    function automatic logic ref_mis(input mem_dt_e dt, input int a);
        return (a % size_of(dt)) != 0;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic we, input mem_dt_e dt, input int a);
        if (!we) return 4'b0000;
        return 4'(((1 << size_of(dt)) - 1) << a);
    endfunction

    function automatic logic [31:0] ref_wdata(input mem_dt_e dt, input logic [31:0] wd);
        if (size_of(dt) == 1) return (wd & 32'hff) * 32'h01010101;
        if (size_of(dt) == 2) return (wd & 32'hffff) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input mem_dt_e dt, input int a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * a);
        if (size_of(dt) == 1) begin
            v = v & 32'hff;
            if (dt == BYTE && v >= 32'h80) v = v | 32'hffffff00;
        end else if (size_of(dt) == 2) begin
            v = v & 32'hffff;
            if (dt == HALF && v >= 32'h8000) v = v | 32'hffff0000;
        end
        return v;
    endfunction

    // rdly: cycles with req_ready low before acceptance; d: response delay after
    // acceptance in cycles, 0 meaning the bus never answers.
    task automatic run_op(input logic we, input mem_dt_e dt, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rword,
                          input int rdly, input int d, input string nm);
        int   a;
        int   fin;
        logic mis;
        logic exp_rv;
        a   = int'(addr[1:0]);
        mis = ref_mis(dt, a);
        fin = mis ? 0 : (d > 0 ? rdly + d : rdly + 1 + TMO);
        m_en = 1'b1; m_we = we; m_dt = dt; m_addr = addr; m_wd = wd;
        for (int c = 0; c <= fin; c++) begin
            req_ready  = mis ? 1'($urandom_range(0, 1)) : c < rdly ? 1'b0 : c == rdly ? 1'b1 : 1'($urandom_range(0, 1));
            resp_valid = (d > 0 && !mis && c == rdly + d) ? 1'b1 : (mis || c <= rdly) ? 1'($urandom_range(0, 1)) : 1'b0;
            resp_rdata = (c == rdly + d) ? rword : $urandom;
            @(negedge clk);
            exp_rv = !mis && c <= rdly;
            chk({nm, ".req_valid"}, req_valid, exp_rv);
            chk({nm, ".stall"}, stall, !mis && c < fin);
            chk({nm, ".done"}, done, c == fin);
            if (exp_rv) begin
                chk({nm, ".req_addr"}, req_addr, addr & 32'hfffffffc);
                chk({nm, ".req_we"}, req_we, we);
                chk({nm, ".req_wstrb"}, req_wstrb, ref_wstrb(we, dt, a));
                chk({nm, ".req_wdata"}, req_wdata, ref_wdata(dt, wd));
            end
            if (c == fin) begin
                chk({nm, ".err"}, err, mis ? EALIGN : d > 0 ? ENOERR : ETIMEOUT);
                if (mis || d == 0) chk({nm, ".m_rd"}, m_rd, 32'h0);
                else if (!we) chk({nm, ".m_rd"}, m_rd, ref_load(dt, a, rword));
            end
            @(posedge clk); #1;
        end
        m_en = 1'b0; req_ready = 1'($urandom_range(0, 1)); resp_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({nm, ".idle_done"}, done, 1'b0);
        chk({nm, ".idle_stall"}, stall, 1'b0);
        chk({nm, ".idle_req_valid"}, req_valid, 1'b0);
        @(posedge clk); #1;
        req_ready = 1'b0; resp_valid = 1'b0;
    endtask

    initial begin
        m_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req_valid", req_valid, 1'b0);
        chk("rst.stall", stall, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.m_rd", m_rd, 32'h0);
        chk("rst.err", err, ENOERR);
        @(posedge clk); #1;
        m_en = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, WORD,  32'h0, 32'h0,        32'hdeadc0de, 0, 1, "lw0");
        run_op(1'b0, BYTE,  32'h3, 32'h0,        32'hdeadc0de, 0, 1, "lb3");
        run_op(1'b0, UBYTE, 32'h3, 32'h0,        32'hdeadc0de, 0, 1, "lbu3");
        run_op(1'b0, HALF,  32'h2, 32'h0,        32'h8001c0de, 0, 1, "lh2");
        run_op(1'b0, UHALF, 32'h2, 32'h0,        32'h8001c0de, 0, 1, "lhu2");
        run_op(1'b1, HALF,  32'h6, 32'h1234abcd, 32'h0,        0, 1, "sh6");
        run_op(1'b1, BYTE,  32'h1, 32'h55,       32'h0,        0, 1, "sb1");
        run_op(1'b0, WORD,  32'h2, 32'h0,        32'h0,        0, 1, "lw2_mis");
        run_op(1'b0, HALF,  32'h1, 32'h0,        32'h0,        0, 1, "lh1_mis");
        run_op(1'b0, WORD,  32'h8, 32'h0,        32'hcafef00d, 3, 2, "backpressure");
        run_op(1'b0, WORD,  32'hc, 32'h0,        32'h0,        0, 0, "timeout");
        run_op(1'b0, HALF,  32'h12, 32'h0,       32'h7fff8000, 1, 5, "resp_at_limit");

        m_en = 1'b1; m_we = 1'b0; m_dt = WORD; m_addr = 32'h40; req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        chk("rstmid.req_valid", req_valid, 1'b0);
        chk("rstmid.stall", stall, 1'b0);
        chk("rstmid.done", done, 1'b0);
        chk("rstmid.m_rd", m_rd, 32'h0);
        chk("rstmid.err", err, ENOERR);
        @(posedge clk); #1;
        rst = 1'b1; m_en = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_resp.done", done, 1'b0);
        chk("late_resp.m_rd", m_rd, 32'h0);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        run_op(1'b0, WORD, 32'h40, 32'h0, 32'h0badf00d, 0, 1, "lw_after_rst");

        for (int i = 0; i < 200; i++) begin
            run_op(1'($urandom_range(0, 1)), mem_dt_e'($urandom_range(0, 4)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
